// File: rtl/btn_kbd_fifo.sv
// Keyboard stage behind the four button debouncers: maps presses and auto-repeat
// ticks to character codes, buffers them in a FIFO, and exposes KBSR/KBDR with pop-on-read.
module btn_kbd_fifo #(
  parameter logic [7:0]  CODE0      = 8'h30,
  parameter logic [7:0]  CODE1      = 8'h31,
  parameter logic [7:0]  CODE2      = 8'h32,
  parameter logic [7:0]  CODE3      = 8'h33,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter logic [23:0] REP_DELAY  = 24'd5_000_000,
  parameter logic [23:0] REP_RATE   = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  lvl,
  input  logic [3:0]  press,
  input  logic        rd,
  output logic [15:0] kbsr,
  output logic [15:0] kbdr,
  output logic        ovf
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_state_e;

  rep_state_e  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  lvl_q;
  logic [3:0]  pending_q, pending_d;
  logic        ovf_q, ovf_d;
  ptr_t        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];

  logic        tick, restart;
  logic [3:0]  tick_mask, svc_mask;
  logic        svc, push, pop, drop, empty, full;
  logic [7:0]  push_code;

  // Auto-repeat: a press or any lvl change restarts timing; a tick due this cycle
  // is still honoured even if the same cycle restarts (e.g. release on a tick).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    case (state_q)
      ST_DELAY: begin
        if (cnt_q == REP_DELAY - 24'd1) begin
          tick    = 1'b1;
          state_d = ST_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_REPEAT: begin
        if (cnt_q == REP_RATE - 24'd1) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: cnt_d = '0;
    endcase
    restart = (|press) || (lvl != lvl_q);
    if (restart) begin
      cnt_d   = '0;
      state_d = $onehot(lvl) ? ST_DELAY : ST_IDLE;
    end
    tick_mask = tick ? lvl_q : '0;
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

  always_comb begin
    svc_mask = pending_q & (~pending_q + 4'd1);
    svc      = |pending_q;
    unique case (svc_mask)
      4'b0001: push_code = CODE0;
      4'b0010: push_code = CODE1;
      4'b0100: push_code = CODE2;
      4'b1000: push_code = CODE3;
      default: push_code = '0;
    endcase
    pop       = rd && !empty;
    push      = svc && (!full || rd);
    drop      = svc && full && !rd;
    pending_d = (pending_q & ~svc_mask) | press | tick_mask;
    wptr_d    = push ? wptr_q + ptr_t'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + ptr_t'(1) : rptr_q;
    ovf_d     = drop ? 1'b1 : (rd ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lvl_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= push_code;
  end

  assign kbsr = {!empty, 15'b0};
  assign kbdr = empty ? '0 : {8'h00, mem_q[rptr_q[DEPTH_LOG2-1:0]]};
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_btn_kbd_fifo.sv
// Directed bench for btn_kbd_fifo with short repeat timing (delay 20, rate 5).
module tb_btn_kbd_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  lvl, press;
  logic        rd;
  logic [15:0] kbsr, kbdr;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  btn_kbd_fifo #(
    .CODE0(8'h30), .CODE1(8'h31), .CODE2(8'h32), .CODE3(8'h33),
    .DEPTH_LOG2(2), .REP_DELAY(24'd20), .REP_RATE(24'd5)
  ) dut (
    .clk(clk), .reset(reset), .lvl(lvl), .press(press), .rd(rd),
    .kbsr(kbsr), .kbdr(kbdr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; lvl = '0; press = '0; rd = 1'b0;
    step(2);
    reset = 1'b0;
    chk("rst_kbsr", kbsr, 16'h0000);
    chk("rst_kbdr", kbdr, 16'h0000);
    chk("rst_ovf", {15'b0, ovf}, 16'h0000);

    // single press of button 2: visible two cycles later, one read empties it
    press = 4'b0100; step(1);
    press = '0;
    chk("p2_lat1_kbsr", kbsr, 16'h0000);
    step(1);
    chk("p2_kbsr", kbsr, 16'h8000);
    chk("p2_kbdr", kbdr, 16'h0032);
    step(2);
    rd = 1'b1; step(1); rd = 1'b0;
    chk("p2_rd_kbsr", kbsr, 16'h0000);
    chk("p2_rd_kbdr", kbdr, 16'h0000);

    // simultaneous presses are serialized lowest index first
    press = 4'b1011; step(1);
    press = '0; step(4);
    chk("multi_kbsr", kbsr, 16'h8000);
    chk("multi_head0", kbdr, 16'h0030);
    rd = 1'b1; step(1);
    chk("multi_head1", kbdr, 16'h0031);
    step(1);
    chk("multi_head2", kbdr, 16'h0033);
    step(1);
    chk("multi_empty_kbsr", kbsr, 16'h0000);
    chk("multi_empty_kbdr", kbdr, 16'h0000);
    step(1); rd = 1'b0;
    chk("underflow_kbsr", kbsr, 16'h0000);
    chk("underflow_kbdr", kbdr, 16'h0000);
    chk("underflow_ovf", {15'b0, ovf}, 16'h0000);

    // six presses into a depth-4 FIFO: last two dropped
    press = 4'b0001; step(1);
    press = 4'b0010; step(1);
    press = 4'b0100; step(1);
    press = 4'b1000; step(1);
    press = 4'b0001; step(1);
    press = 4'b0010; step(1);
    press = '0; step(2);
    chk("ovf_set", {15'b0, ovf}, 16'h0001);
    chk("ovf_head", kbdr, 16'h0030);
    rd = 1'b1; step(1); rd = 1'b0;
    chk("ovf_clr", {15'b0, ovf}, 16'h0000);
    chk("ovf_next", kbdr, 16'h0031);

    // refill to full (31,32,33,30), then service a press in the same cycle as rd
    press = 4'b0001; step(1);
    press = '0; step(1);
    chk("full_kbsr", kbsr, 16'h8000);
    press = 4'b0100; step(1);
    press = '0; rd = 1'b1; step(1); rd = 1'b0;
    chk("fullrd_ovf", {15'b0, ovf}, 16'h0000);
    chk("fullrd_head", kbdr, 16'h0032);
    rd = 1'b1; step(1);
    chk("fullrd_e1", kbdr, 16'h0033);
    step(1);
    chk("fullrd_e2", kbdr, 16'h0030);
    step(1);
    chk("fullrd_tail", kbdr, 16'h0032);
    step(1); rd = 1'b0;
    chk("fullrd_empty", kbsr, 16'h0000);
    chk("fullrd_ovf2", {15'b0, ovf}, 16'h0000);

    reset = 1'b1; step(2); reset = 1'b0;

    // auto-repeat: pushes at cycles 1,21,26,31 visible at 2,22,27,32; read each one
    for (int c = 0; c < 46; c++) begin
      logic exp_rdy;
      exp_rdy = (c == 2) || (c == 22) || (c == 27) || (c == 32);
      lvl   = (c < 33) ? 4'b0001 : 4'b0000;
      press = (c == 0) ? 4'b0001 : 4'b0000;
      rd    = exp_rdy;
      chk($sformatf("rep_kbsr_c%0d", c), kbsr, {exp_rdy, 15'b0});
      chk($sformatf("rep_kbdr_c%0d", c), kbdr, exp_rdy ? 16'h0030 : 16'h0000);
      step(1);
    end
    rd = 1'b0;

    // two buttons held: no repeat
    lvl = 4'b0011; step(40);
    chk("twohold_kbsr", kbsr, 16'h0000);

    // fill, overflow, then reset with press and rd asserted
    press = 4'b1111; step(1);
    press = '0; step(4);
    chk("fill_kbsr", kbsr, 16'h8000);
    chk("fill_head", kbdr, 16'h0030);
    press = 4'b1111; step(1);
    press = '0; step(1);
    chk("fill_ovf", {15'b0, ovf}, 16'h0001);
    reset = 1'b1; press = 4'b1111; rd = 1'b1; step(1);
    reset = 1'b0; press = '0; rd = 1'b0;
    chk("midrst_kbsr", kbsr, 16'h0000);
    chk("midrst_kbdr", kbdr, 16'h0000);
    chk("midrst_ovf", {15'b0, ovf}, 16'h0000);
    step(3);
    chk("midrst_pending_kbsr", kbsr, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_kbd_fifo.md
# btn_kbd_fifo

Keyboard-device stage that sits directly downstream of the four button debouncers on the LC3 board. It consumes each debouncer's level and press-pulse outputs, maps presses to 8-bit character codes, and generates auto-repeat while a single button is held. Codes are buffered in a small FIFO. The FIFO is exposed to the LC3 memory-mapped I/O decoder as KBSR/KBDR registers, with pop-on-read semantics.

## Interface
- CODE0, 8'h30, character code for button 0
- CODE1, 8'h31, character code for button 1
- CODE2, 8'h32, character code for button 2
- CODE3, 8'h33, character code for button 3
- DEPTH_LOG2, 2, FIFO depth is 2^DEPTH_LOG2 entries (default 4)
- REP_DELAY, 24'd5_000_000, hold cycles before the first auto-repeat
- REP_RATE, 24'd1_000_000, cycles between subsequent repeats
- clk  input  1  system clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- lvl  input  4  debounced level per button
- press  input  4  one-cycle press pulse per button
- rd  input  1  KBDR read strobe, one cycle; pops the FIFO head
- kbsr  output  16  {ready, 15'b0}; ready = FIFO non-empty
- kbdr  output  16  {8'h00, head code}; 16'h0000 when empty
- ovf  output  1  sticky: a code was dropped because the FIFO was full

## Operation
- Reset (synchronous): FIFO emptied, pending[3:0]=0, repeat counter=0, repeat phase=IDLE, ovf=0. Result: kbsr=0, kbdr=0.
- Pending register pending[3:0]:
  - pending[i] is set on a cycle where press[i]=1 or a repeat tick targets button i.
  - Each cycle, the lowest-index pending bit, if any, is serviced.
  - Service while the FIFO is not full (or is full but rd=1 in the same cycle): push CODEi and clear the bit.
  - Service while the FIFO is full and rd=0: clear the bit without pushing, and set ovf.
- Only one push per cycle. Simultaneous presses are serialized lowest index first, one per cycle.
- Pop: rd=1 with FIFO non-empty removes the head. rd=1 on an empty FIFO is ignored and has no side effects.
- ovf clears on any cycle with rd=1, unless a drop occurs in that same cycle (set wins).
- Auto-repeat FSM:
  - IDLE: entered whenever lvl is not one-hot.
  - DELAY: entered when lvl is one-hot; counter counts up to REP_DELAY.
  - REPEAT: on reaching the count, issue a tick and restart the count at REP_RATE; issue a tick at each subsequent expiry.
  - Any press pulse, or any change of lvl, returns the FSM to DELAY (if lvl is one-hot) or IDLE, with the counter cleared.
  - A tick sets pending for the single held button.
- Counter is 24 bits and never wraps: it is cleared at each tick or state change.
- FIFO pointers are DEPTH_LOG2+1 bits wide. Full/empty are determined by pointer MSB comparison.

## Timing
- press[i] in cycle k sets pending at edge k. Push occurs at edge k+1. kbsr[15]=1 and kbdr valid from cycle k+2, given an empty FIFO and no lower-index pending bits.
- rd in cycle k pops at edge k. The next head, or kbsr=0 and kbdr=0 if the FIFO is now empty, is visible in cycle k+1.
- Simultaneous push and pop:
  - FIFO non-empty and not full: count is unchanged.
  - FIFO full: the push succeeds and no drop occurs.
  - FIFO empty: only the push takes effect.
- Auto-repeat timing, for a button held from cycle k (press pulse in cycle k):
  - First repeat tick at cycle k+REP_DELAY.
  - Subsequent ticks every REP_RATE cycles.
  - Each tick is followed by a push one cycle later.
- Release (lvl falls) in the same cycle as a tick: the tick is still honoured, and the FSM goes to IDLE.
- Reset asserted mid-operation overrides all inputs in that cycle, including press and rd.

## Test plan
- Reset, then press[2] pulse at cycle 10 -> kbsr=16'h8000 and kbdr=16'h0032 from cycle 12; rd at cycle 15 -> kbsr=0 and kbdr=0 at cycle 16.
- press=4'b1011 in a single cycle -> FIFO holds 8'h30, 8'h31, 8'h33 in that order; four rd strobes return them in order, then the empty FIFO reads 0 with no underflow.
- 6 separate presses with no reads (DEPTH=4) -> first 4 codes retained, ovf=1; the next rd clears ovf and returns the first code.
- FIFO full with press and rd in the same cycle -> no drop, ovf stays 0, the new code lands at the tail.
- REP_DELAY=20, REP_RATE=5, hold lvl=4'b0001 with a press at cycle 0 -> pushes of 8'h30 at cycles 1, 21, 26, 31; release at cycle 33 -> no further pushes.
- lvl=4'b0011 held (not one-hot) -> no repeat ticks; reset asserted while pending bits and FIFO are non-empty -> kbsr=0, kbdr=0, ovf=0 the next cycle.
